// File: rtl/int_mul_pipelined_pkg.sv
`default_nettype none
// ============================================================================
// Module   : int_mul_pipelined_pkg
// Purpose  : Shared ALU func3 constants and request struct for the integer
//            multiplier pipeline.
// Revision : 1.0  initial release
// ============================================================================
package int_mul_pipelined_pkg;

    // Widest operand and tag the request struct can carry; narrower
    // configurations occupy the low bits.
    localparam int MUL_XLEN_MAX  = 64;
    localparam int MUL_TAG_W_MAX = 16;

    localparam logic [2:0] MUL_FUNC3    = 3'b000;
    localparam logic [2:0] MULH_FUNC3   = 3'b001;
    localparam logic [2:0] MULHSU_FUNC3 = 3'b010;
    localparam logic [2:0] MULHU_FUNC3  = 3'b011;

    typedef struct packed {
        logic [2:0]               func3;
        logic [MUL_XLEN_MAX-1:0]  rs1;
        logic [MUL_XLEN_MAX-1:0]  rs2;
        logic [MUL_TAG_W_MAX-1:0] tag;
    } int_mul_req_t;

endpackage
`default_nettype wire

// File: rtl/int_mul_core.sv
`default_nettype none
// ============================================================================
// Module   : int_mul_core
// Purpose  : Combinational RV M-extension product generator and half select.
// Revision : 1.0  initial release
// ============================================================================
module int_mul_core
    import int_mul_pipelined_pkg::*;
#(
    parameter int DATA_LEN = 32,
    parameter int TAG_W    = 6
) (
    input  int_mul_req_t          req_i,
    output logic [DATA_LEN-1:0]   rslt_o,
    output logic [TAG_W-1:0]      tag_o
);

    localparam int PW = 2*DATA_LEN + 2;

    logic                    rs1_sgn;
    logic                    rs2_sgn;
    logic signed [DATA_LEN:0] op1;
    logic signed [DATA_LEN:0] op2;
    logic signed [PW-1:0]    prod;
    logic                    unused_bits;

    always_comb begin
        rs1_sgn = (req_i.func3 == MULH_FUNC3) || (req_i.func3 == MULHSU_FUNC3);
        rs2_sgn = (req_i.func3 == MULH_FUNC3);
        op1     = $signed({rs1_sgn & req_i.rs1[DATA_LEN-1], req_i.rs1[DATA_LEN-1:0]});
        op2     = $signed({rs2_sgn & req_i.rs2[DATA_LEN-1], req_i.rs2[DATA_LEN-1:0]});
        prod    = PW'(op1) * PW'(op2);

        rslt_o = '0;
        case (req_i.func3)
            MUL_FUNC3:                             rslt_o = prod[DATA_LEN-1:0];
            MULH_FUNC3, MULHSU_FUNC3, MULHU_FUNC3: rslt_o = prod[2*DATA_LEN-1:DATA_LEN];
            default:                               rslt_o = '0;
        endcase

        tag_o = req_i.tag[TAG_W-1:0];
        // Struct padding above DATA_LEN/TAG_W and the two product guard bits
        // are intentionally dropped.
        unused_bits = ^{req_i.rs1, req_i.rs2, req_i.tag, prod};
    end

endmodule
`default_nettype wire

// File: rtl/int_mul_pipelined.sv
`default_nettype none
// ============================================================================
// Module   : int_mul_pipelined
// Purpose  : Elastic STAGES-slot integer multiplier with tag sideband and
//            flush. Define INT_MUL_PERF_CNT_EN to add perf counter outputs.
// Revision : 1.0  initial release
// ============================================================================
module int_mul_pipelined
    import int_mul_pipelined_pkg::*;
#(
    parameter int DATA_LEN = 32,
    parameter int STAGES   = 2,
    parameter int TAG_W    = 6
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [2:0]          in_func3,
    input  logic [DATA_LEN-1:0] in_rs1,
    input  logic [DATA_LEN-1:0] in_rs2,
    input  logic [TAG_W-1:0]    in_tag,
    input  logic                flush,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [DATA_LEN-1:0] out_rslt,
    output logic [TAG_W-1:0]    out_tag
`ifdef INT_MUL_PERF_CNT_EN
    ,
    output logic [31:0]         perf_mul_cnt,
    output logic [31:0]         perf_stall_cnt
`endif
);

    int_mul_req_t          req;
    logic [DATA_LEN-1:0]   core_rslt;
    logic [TAG_W-1:0]      core_tag;
    logic                  accept;
    logic [STAGES-1:0]     adv;
    logic [STAGES-1:0]     valid_q, valid_d;
    logic [DATA_LEN-1:0]   rslt_q [STAGES];
    logic [DATA_LEN-1:0]   rslt_d [STAGES];
    logic [TAG_W-1:0]      tag_q  [STAGES];
    logic [TAG_W-1:0]      tag_d  [STAGES];

    always_comb begin
        req       = '0;
        req.func3 = in_func3;
        req.rs1   = MUL_XLEN_MAX'(in_rs1);
        req.rs2   = MUL_XLEN_MAX'(in_rs2);
        req.tag   = MUL_TAG_W_MAX'(in_tag);
    end

    int_mul_core #(
        .DATA_LEN (DATA_LEN),
        .TAG_W    (TAG_W)
    ) u_core (
        .req_i  (req),
        .rslt_o (core_rslt),
        .tag_o  (core_tag)
    );

    // Advance resolves from the output backwards so a full pipe still
    // moves every slot in the same cycle the consumer takes a result.
    always_comb begin
        adv = '0;
        adv[STAGES-1] = valid_q[STAGES-1] & out_ready;
        for (int k = STAGES-2; k >= 0; k--) begin
            adv[k] = valid_q[k] & (~valid_q[k+1] | adv[k+1]);
        end
    end

    assign in_ready  = ~valid_q[0] | adv[0];
    assign accept    = in_valid & in_ready & ~flush;
    assign out_valid = valid_q[STAGES-1] & ~flush;
    assign out_rslt  = rslt_q[STAGES-1];
    assign out_tag   = tag_q[STAGES-1];

    always_comb begin
        valid_d = valid_q;
        rslt_d  = rslt_q;
        tag_d   = tag_q;
        for (int k = 0; k < STAGES; k++) begin
            if (adv[k]) valid_d[k] = 1'b0;
        end
        if (accept) begin
            valid_d[0] = 1'b1;
            rslt_d[0]  = core_rslt;
            tag_d[0]   = core_tag;
        end
        for (int k = 1; k < STAGES; k++) begin
            if (adv[k-1]) begin
                valid_d[k] = 1'b1;
                rslt_d[k]  = rslt_q[k-1];
                tag_d[k]   = tag_q[k-1];
            end
        end
        if (flush) valid_d = '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
            for (int k = 0; k < STAGES; k++) begin
                rslt_q[k] <= '0;
                tag_q[k]  <= '0;
            end
        end else begin
            valid_q <= valid_d;
            rslt_q  <= rslt_d;
            tag_q   <= tag_d;
        end
    end

`ifdef INT_MUL_PERF_CNT_EN
    logic [31:0] mul_cnt_q;
    logic [31:0] stall_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mul_cnt_q   <= '0;
            stall_cnt_q <= '0;
        end else begin
            if (accept && (mul_cnt_q != '1))
                mul_cnt_q <= mul_cnt_q + 32'd1;
            if (out_valid && !out_ready && (stall_cnt_q != '1))
                stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign perf_mul_cnt   = mul_cnt_q;
    assign perf_stall_cnt = stall_cnt_q;
`endif

endmodule
`default_nettype wire

// File: doc/int_mul_pipelined.md
INT_MUL_PIPELINED -- requirements
Module: int_mul_pipelined

Interface
REQ-001 Parameters SHALL be, one per line as name, default, meaning:
  DATA_LEN  32  operand/result width, legal values 32 or 64
  STAGES  2  accept-to-result latency in cycles, legal range 1..4
  TAG_W  6  width of the ROB/tag sideband carried with each operation
REQ-002 Ports SHALL be, one per line as name, direction, width, meaning:
  clk  in  1  single clock, rising-edge
  rst  in  1  reset, asynchronous, active-high
  in_valid  in  1  request valid
  in_ready  out  1  pipe can accept this cycle
  in_func3  in  3  RV M-ext func3 (MUL/MULH/MULHSU/MULHU)
  in_rs1  in  DATA_LEN  multiplicand
  in_rs2  in  DATA_LEN  multiplier
  in_tag  in  TAG_W  sideband tag
  flush  in  1  kill all in-flight operations
  out_valid  out  1  result valid
  out_ready  in  1  consumer accepts result
  out_rslt  out  DATA_LEN  selected product half
  out_tag  out  TAG_W  tag of out_rslt

Function
REQ-003 A request SHALL transfer only on a cycle with in_valid && in_ready; a result SHALL transfer only on a cycle with out_valid && out_ready.
REQ-004 Pipeline SHALL be elastic, with STAGES slots, one valid bit per slot; slot k SHALL advance when slot k+1 is empty or advancing; the last slot advances on out_ready.
REQ-005 in_ready SHALL be combinational: !slot0_valid || slot0_advancing; sustained throughput SHALL be 1 op/cycle while out_ready=1.
REQ-006 With no backpressure, out_valid SHALL assert exactly STAGES cycles after the accept edge.
REQ-007 Operands SHALL be extended to DATA_LEN+1 bits (rs1 signed for MULH/MULHSU, rs2 signed for MULH only; otherwise zero-extended) and a 2*DATA_LEN+2-bit signed product formed.
REQ-008 MUL (000) SHALL return product[DATA_LEN-1:0]; MULH (001), MULHSU (010) and MULHU (011) SHALL return product[2*DATA_LEN-1:DATA_LEN].
REQ-009 func3[2]=1 SHALL be accepted and SHALL return all-zero with its tag.
REQ-010 When out_valid && !out_ready, out_rslt/out_tag SHALL hold stable and slot contents SHALL NOT be overwritten.
REQ-011 flush SHALL clear every slot valid on the next edge; a request presented in the flush cycle SHALL be dropped; out_valid SHALL be 0 the cycle after flush.
REQ-012 Tags SHALL emerge in accept order; no reordering.

Reset
REQ-013 On rst assertion, all slot valids, out_valid, out_rslt and out_tag SHALL go to 0 immediately, independent of clk; in-flight ops SHALL be discarded.
REQ-014 in_ready SHALL be 1 in the first cycle after rst deasserts.

Configuration
REQ-015 When INT_MUL_PERF_CNT_EN is defined, the block SHALL add outputs perf_mul_cnt (32, counts accepts) and perf_stall_cnt (32, counts cycles with out_valid && !out_ready); both saturate at all-ones and reset to 0.
REQ-016 When INT_MUL_PERF_CNT_EN is undefined, those ports and counters SHALL be absent, with all other behaviour identical.

Structure
REQ-017 MUL_FUNC3..MULHU_FUNC3 SHALL come from the shared ALU constants package; int_mul_req_t (func3, rs1, rs2, tag) SHALL be defined in the shared structs package.
REQ-018 Product generation SHALL be a single combinational sub-module int_mul_core in slot 0, with later slots being registers available for retiming.

Verification
REQ-019 DATA_LEN=32, STAGES=2: MULH 0x80000000*0x80000000 -> out_rslt 0x40000000, out_valid 2 cycles after accept.
REQ-020 MULHSU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFF; MULHU same operands -> 0xFFFFFFFE; MUL same operands -> 0x00000001.
REQ-021 Back-to-back 8 ops, tags 0..7, with out_ready low for cycles 3-5 -> no loss, no duplication, tags emerge in order 0..7, out_rslt stable while stalled.
REQ-022 flush in the cycle after accepting tags 1,2 with in_valid=1 (tag 3) -> out_valid never asserts for tags 1,2,3; next op (tag 4) returns after 2 cycles.
REQ-023 rst asserted mid-stream between clock edges -> out_valid drops within the same cycle; after release in_ready=1 and a MUL 3*5 returns 15.
REQ-024 With INT_MUL_PERF_CNT_EN defined: 5 accepts and 3 stalled cycles -> perf_mul_cnt=5, perf_stall_cnt=3.
